spi_peripheral: RTL

- SPI mode 0 (CPOL=0, CPHA=0) peripheral. It is the responder end for the core's SPI controller port (spi_sck/spi_mosi/spi_miso).
- Oversamples the controller's SCK in the sys_clk domain, shifts MSB-first words in on MOSI, and shifts words out on MISO.
- Presents received words and accepts transmit words through valid/ready handshakes.
- Used as the on-chip loopback/target device for core SPI bring-up and as a reusable peripheral.

---
 rtl/spi_peripheral.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// SPI mode 0 responder: oversamples SCK/MOSI/CS_N in sys_clk, shifts MSB-first
// words in on MOSI and out on MISO, with a one-entry transmit holding register.
module spi_peripheral #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  cpu_rst,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  spi_miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]             state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   cs_armed;

  logic                   sck_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  logic [DATA_WIDTH-1:0]  hold_data;
  logic                   hold_full;
  logic                   hold_capture;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   load_pending;
  logic                   do_load;
  logic [DATA_WIDTH-1:0]  load_word;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // sync_fill marks when the chains hold real samples rather than reset values,
  // so a CS_N held low through reset cannot masquerade as a falling edge.
  always_ff @(posedge sys_clk) begin
    if (cpu_rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sync_fill <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
      cs_armed  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
      if (sync_fill[SYNC_STAGES-1] && cs_s) cs_armed <= 1'b1;
    end
  end

  always_comb begin
    sck_rise     = sck_s & ~sck_prev;
    sck_fall     = ~sck_s & sck_prev;
    cs_rise      = cs_s & ~cs_prev;
    cs_fall      = cs_armed & cs_prev & ~cs_s;
    hold_capture = tx_valid & ~hold_full;
    do_load      = ((state == IDLE) && cs_fall) ||
                   ((state == ACTIVE) && !cs_rise && sck_fall && load_pending);
    load_word    = hold_full ? hold_data : '0;
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state == ACTIVE);

  // Capture is only possible while empty, so a same-cycle load has already
  // taken zeros and the new word simply fills the entry.
  always_ff @(posedge sys_clk) begin
    if (cpu_rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (hold_capture) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end else if (do_load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (cpu_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_underrun  <= 1'b0;
      spi_miso     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (do_load) begin
        tx_shift    <= load_word;
        spi_miso    <= load_word[DATA_WIDTH-1];
        tx_underrun <= ~hold_full;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state        <= ACTIVE;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            spi_miso     <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              rx_data      <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
              rx_valid     <= 1'b1;
              bit_cnt      <= '0;
              load_pending <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            if (load_pending) begin
              load_pending <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              spi_miso <= tx_shift[DATA_WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
